// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the ARM-subset datapath: fetch/decode FSM, NZCV
// flag register, condition evaluation and bounded memory-wait handling.
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_write,
  output logic        mem_req,
  output logic        pc_src,
  output logic        mem_reg,
  output logic        alu_src,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic [3:0]  alu_control,
  output logic [3:0]  flags,
  output logic        timeout,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_DP  = 4'd2;
  localparam logic [3:0] S_ALU_WB   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  // The counter holds the number of stalled cycles already spent; the
  // stalled cycle that would make it MEM_WAIT_MAX is the one that times out.
  localparam int CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  logic [3:0]    state_q, state_d;
  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       i_bit, s_bit, u_bit, rd_pc;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_pass;
  logic [3:0] dp_alu;
  logic       dp_ok, dp_logic, dp_cmp;
  logic       unused_instr_bits;

  assign cond   = instruction[31:28];
  assign op     = instruction[27:26];
  assign i_bit  = instruction[25];
  assign cmd    = instruction[24:21];
  assign u_bit  = instruction[23];
  assign s_bit  = instruction[20];
  assign rd_pc  = (instruction[15:12] == 4'hF);
  assign unused_instr_bits = ^{instruction[19:16], instruction[11:0]};

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    dp_alu   = ALU_ADD;
    dp_ok    = 1'b1;
    dp_logic = 1'b0;
    dp_cmp   = 1'b0;
    case (cmd)
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b0000: begin dp_alu = ALU_AND; dp_logic = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; dp_logic = 1'b1; end
      4'b1010: begin dp_alu = ALU_SUB; dp_cmp = 1'b1; end
      default: dp_ok = 1'b0;
    endcase
  end

  // Memory handshake: mem_req is held for the whole MEM_RD/MEM_WR stay and the
  // access completes in the cycle where mem_req && mem_ready are both high.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    cnt_d       = '0;
    timeout_d   = timeout_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    mem_req     = 1'b0;
    pc_src      = 1'b0;
    mem_reg     = 1'b0;
    alu_src     = 1'b0;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_pass) state_d = S_FETCH;
        else begin
          case (op)
            2'b00:   state_d = S_EXEC_DP;
            2'b01:   state_d = S_MEM_ADDR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC_DP: begin
        alu_src     = i_bit;
        alu_control = dp_alu;
        if (dp_ok && (s_bit || dp_cmp))
          flags_d = dp_logic ? {alu_flags[3:2], flags_q[1:0]} : alu_flags;
        state_d = (!dp_ok || dp_cmp) ? S_FETCH : S_ALU_WB;
      end
      S_ALU_WB: begin
        if (rd_pc) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else begin
          reg_write = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        imm_src     = 2'b01;
        alu_src     = !i_bit;
        alu_control = u_bit ? ALU_ADD : ALU_SUB;
        state_d     = s_bit ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
        else if (cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_MEM_WB: begin
        mem_reg = 1'b1;
        if (rd_pc) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else begin
          reg_write = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        reg_src = 2'b10;
        mem_req = 1'b1;
        if (mem_ready) begin
          mem_write = 1'b1;
          state_d   = S_FETCH;
        end else if (cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_BRANCH: begin
        reg_src     = 2'b01;
        imm_src     = 2'b10;
        alu_src     = 1'b1;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
        pc_src      = 1'b1;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset holds the state at FETCH, so its enables must be suppressed too.
    if (!rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'b0000;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flags     = flags_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a table of whole instructions with
// hand-computed cycle/pulse/flag expectations plus a reset-during-wait sequence.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_write, ir_write, reg_write, mem_write, mem_req;
  logic        pc_src, mem_reg, alu_src;
  logic [1:0]  imm_src, reg_src;
  logic [3:0]  alu_control, flags, state_dbg;
  logic        timeout;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .alu_flags(alu_flags),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_write(mem_write), .mem_req(mem_req),
    .pc_src(pc_src), .mem_reg(mem_reg), .alu_src(alu_src), .imm_src(imm_src),
    .reg_src(reg_src), .alu_control(alu_control), .flags(flags),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  af;
    int          waitn;
    int          cyc;
    int          rw;
    int          mw;
    int          pcw;
    int          pcs;
    int          mr;
    int          req;
    logic [3:0]  fl;
    logic        to;
    logic [3:0]  alu;
    logic [4:0]  ctl;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] af,
                              input int waitn, input int cyc, input int rw,
                              input int mw, input int pcw, input int pcs,
                              input int mr, input int req, input logic [3:0] fl,
                              input logic to, input logic [3:0] alu,
                              input logic [4:0] ctl);
    vec_t v;
    v.instr = instr; v.af = af; v.waitn = waitn; v.cyc = cyc; v.rw = rw;
    v.mw = mw; v.pcw = pcw; v.pcs = pcs; v.mr = mr; v.req = req;
    v.fl = fl; v.to = to; v.alu = alu; v.ctl = ctl;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
  endtask

  // Entered from the low phase of a FETCH cycle; returns at the next FETCH.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, rw = 0, mw = 0, pcw = 0, pcs = 0, mr = 0, req = 0, stall = 0;
    logic [3:0] alu3 = 4'b0000;
    logic [4:0] ctl3 = 5'b00000;
    bit done = 1'b0;
    instruction = v.instr;
    alu_flags   = v.af;
    while (!done) begin
      mem_ready = mem_req ? (stall >= v.waitn) : 1'b1;
      #1;
      cyc++;
      rw  += int'(reg_write);
      mw  += int'(mem_write);
      pcw += int'(pc_write);
      pcs += int'(pc_write && pc_src);
      mr  += int'(mem_reg);
      req += int'(mem_req);
      if (cyc == 3) begin
        alu3 = alu_control;
        ctl3 = {alu_src, imm_src, reg_src};
      end
      if (mem_req && !mem_ready) stall++;
      @(negedge clk);
      if (ir_write) done = 1'b1;
      else if (cyc >= 64) begin
        n_total++;
        $display("FAIL cycle_bound[%0d]: no FETCH within %0d cycles", idx, cyc);
        done = 1'b1;
      end
    end
    chk("cycles",      idx, cyc,  v.cyc);
    chk("reg_write",   idx, rw,   v.rw);
    chk("mem_write",   idx, mw,   v.mw);
    chk("pc_write",    idx, pcw,  v.pcw);
    chk("pc_src",      idx, pcs,  v.pcs);
    chk("mem_reg",     idx, mr,   v.mr);
    chk("mem_req",     idx, req,  v.req);
    chk("flags",       idx, flags, v.fl);
    chk("timeout",     idx, timeout, v.to);
    chk("alu_control", idx, alu3, v.alu);
    chk("mux_selects", idx, ctl3, v.ctl);
  endtask

  initial begin
    //            instr         af     wt  cyc rw mw pcw pcs mr req  flags  to  alu    {alu_src,imm,reg}
    vecs[0]  = mk(32'hE2900000, 4'h4,  0,  4, 1, 0, 1, 0, 0, 0,  4'h4, 0, 4'h0, 5'b10000); // ADDS -> Z
    vecs[1]  = mk(32'h0A000002, 4'h0,  0,  3, 0, 0, 2, 1, 0, 0,  4'h4, 0, 4'h0, 5'b11001); // BEQ taken
    vecs[2]  = mk(32'hE1500001, 4'h0,  0,  3, 0, 0, 1, 0, 0, 0,  4'h0, 0, 4'h1, 5'b00000); // CMP
    vecs[3]  = mk(32'h0A000002, 4'h0,  0,  2, 0, 0, 1, 0, 0, 0,  4'h0, 0, 4'h0, 5'b00000); // BEQ fails
    vecs[4]  = mk(32'hE5901004, 4'h0,  3,  8, 1, 0, 1, 0, 1, 4,  4'h0, 0, 4'h0, 5'b10100); // LDR, 3 waits
    vecs[5]  = mk(32'hE5801004, 4'h0,  2,  6, 0, 1, 1, 0, 0, 3,  4'h0, 0, 4'h0, 5'b10100); // STR, 2 waits
    vecs[6]  = mk(32'hE0310002, 4'hF,  0,  3, 0, 0, 1, 0, 0, 0,  4'h0, 0, 4'h0, 5'b00000); // EORS unsupported
    vecs[7]  = mk(32'hEC000000, 4'hF,  0,  2, 0, 0, 1, 0, 0, 0,  4'h0, 0, 4'h0, 5'b00000); // op 11
    vecs[8]  = mk(32'hE2500001, 4'h3,  0,  4, 1, 0, 1, 0, 0, 0,  4'h3, 0, 4'h1, 5'b10000); // SUBS
    vecs[9]  = mk(32'hE2100001, 4'hC,  0,  4, 1, 0, 1, 0, 0, 0,  4'hF, 0, 4'h2, 5'b10000); // ANDS keeps CV
    vecs[10] = mk(32'hE3900001, 4'h0,  0,  4, 1, 0, 1, 0, 0, 0,  4'h3, 0, 4'h3, 5'b10000); // ORRS keeps CV
    vecs[11] = mk(32'hE2800001, 4'hF,  0,  4, 1, 0, 1, 0, 0, 0,  4'h3, 0, 4'h0, 5'b10000); // ADD, no S
    vecs[12] = mk(32'hE280F004, 4'h0,  0,  4, 0, 0, 2, 1, 0, 0,  4'h3, 0, 4'h0, 5'b10000); // ADD to PC
    vecs[13] = mk(32'hAA000000, 4'h0,  0,  2, 0, 0, 1, 0, 0, 0,  4'h3, 0, 4'h0, 5'b00000); // BGE fails
    vecs[14] = mk(32'hBA000000, 4'h0,  0,  3, 0, 0, 2, 1, 0, 0,  4'h3, 0, 4'h0, 5'b11001); // BLT taken
    vecs[15] = mk(32'h8A000000, 4'h0,  0,  3, 0, 0, 2, 1, 0, 0,  4'h3, 0, 4'h0, 5'b11001); // BHI taken
    vecs[16] = mk(32'h9A000000, 4'h0,  0,  2, 0, 0, 1, 0, 0, 0,  4'h3, 0, 4'h0, 5'b00000); // BLS fails
    vecs[17] = mk(32'h6A000000, 4'h0,  0,  3, 0, 0, 2, 1, 0, 0,  4'h3, 0, 4'h0, 5'b11001); // BVS taken
    vecs[18] = mk(32'hFA000000, 4'h0,  0,  2, 0, 0, 1, 0, 0, 0,  4'h3, 0, 4'h0, 5'b00000); // never
    vecs[19] = mk(32'hE5101004, 4'h0,  0,  5, 1, 0, 1, 0, 1, 1,  4'h3, 0, 4'h1, 5'b10100); // LDR, U=0
    vecs[20] = mk(32'hE591F000, 4'h0,  0,  5, 0, 0, 2, 1, 1, 1,  4'h3, 0, 4'h0, 5'b10100); // LDR to PC
    vecs[21] = mk(32'hE7801002, 4'h0,  0,  4, 0, 1, 1, 0, 0, 1,  4'h3, 0, 4'h0, 5'b00100); // STR reg offset
    vecs[22] = mk(32'hE5901004, 4'h0, 14, 19, 1, 0, 1, 0, 1, 15, 4'h3, 0, 4'h0, 5'b10100); // LDR, 14 waits
    vecs[23] = mk(32'hE5801004, 4'h0, 99, 18, 0, 0, 1, 0, 0, 15, 4'h3, 1, 4'h0, 5'b10100); // STR timeout
    vecs[24] = mk(32'hE2800001, 4'h0,  0,  4, 1, 0, 1, 0, 0, 0,  4'h3, 1, 4'h0, 5'b10000); // sticky timeout

    rst = 1'b0;
    instruction = 32'h0;
    alu_flags = 4'h0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ir_write", 0, ir_write, 1'b0);
    chk("rst_pc_write", 0, pc_write, 1'b0);
    chk("rst_flags",    0, flags,    4'h0);
    chk("rst_timeout",  0, timeout,  1'b0);
    chk("rst_state",    0, state_dbg, 4'd0);
    rst = 1'b1;
    #1;
    chk("first_fetch_ir_write", 0, ir_write, 1'b1);

    for (int i = 0; i < 25; i++) run_vec(i, vecs[i]);

    // Reset while an LDR is stalled in MEM_RD.
    instruction = 32'hE5901004;
    alu_flags = 4'h0;
    mem_ready = 1'b0;
    for (int k = 0; k < 8 && !mem_req; k++) @(negedge clk);
    chk("ldr_reaches_mem_rd", 100, mem_req, 1'b1);
    repeat (2) @(negedge clk);
    chk("ldr_still_waiting", 100, state_dbg, 4'd5);
    rst = 1'b0;
    #1;
    chk("midrst_enables", 100, {pc_write, ir_write, reg_write, mem_write, mem_req}, 5'b00000);
    chk("midrst_flags",   100, flags,     4'h0);
    chk("midrst_timeout", 100, timeout,   1'b0);
    chk("midrst_state",   100, state_dbg, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_first_fetch", 100, ir_write, 1'b1);
    run_vec(101, mk(32'hE2900000, 4'h4, 0, 4, 1, 0, 1, 0, 0, 0, 4'h4, 0, 4'h0, 5'b10000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Sequencing control unit for the ARM-subset processor datapath.
- Fetches each instruction into an instruction register via `ir_write` and decodes the condition, op and funct fields.
- Steps the datapath through per-class micro-states: data-processing, LDR/STR and B.
- Holds the NZCV status flags, evaluates condition codes, and stalls on memory reads until the data memory reports ready.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: cycles allowed in MEM_RD before the access is abandoned as a timeout.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `instruction`  in  32: current instruction register contents.
- `alu_flags`  in  4: {N,Z,C,V} from the ALU for the operation in the current cycle.
- `mem_ready`  in  1: data memory has read data valid / write accepted.
- `pc_write`, `ir_write`, `reg_write`, `mem_write`, `mem_req`  out  1 each: enables.
- `pc_src`, `mem_reg`, `alu_src`  out  1 each: datapath mux selects.
- `imm_src`  out  2: 00 imm8, 01 imm12, 10 imm24.
- `reg_src`  out  2: bit0 selects PC as A1; bit1 selects Rd as A2.
- `alu_control`  out  4: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR.
- `flags`  out  4: architectural NZCV register.
- `timeout`  out  1: sticky; set on a memory wait timeout.

## Operation
- States: FETCH, DECODE, EXEC_DP, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH.
- FETCH: `ir_write`=1, `pc_write`=1, `pc_src`=0 (PC+4). Next state is DECODE.
- DECODE: evaluate cond = instr[31:28] against `flags`.
  - Codes 0000–1101 follow ARM semantics (EQ..LE); 1110 = AL; 1111 = never.
  - Condition fails → FETCH.
  - op = instr[27:26]: 00 → EXEC_DP, 01 → MEM_ADDR, 10 → BRANCH, 11 → FETCH (squashed).
- EXEC_DP: `alu_src` = instr[25]; `imm_src`=00.
  - cmd instr[24:21] mapping: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no write).
  - Any other cmd: `alu_control`=ADD, no writes, → FETCH.
  - Flags load `alu_flags` at the end of this cycle if S (instr[20]) = 1 or cmd = CMP.
  - Flag write masks for logical ops (AND, ORR): N and Z only; C and V are held.
  - CMP → FETCH; otherwise → ALU_WB.
- ALU_WB: `mem_reg`=0.
  - Rd ≠ 15: `reg_write`=1.
  - Rd = 15: `reg_write`=0, `pc_write`=1, `pc_src`=1.
  - Next state is FETCH.
- MEM_ADDR: `imm_src`=01, `alu_src` = ~instr[25], `alu_control` = ADD if U (instr[23]) = 1, else SUB.
  - L (instr[20]) = 1 → MEM_RD; L = 0 → MEM_WR.
- MEM_RD: `mem_req`=1.
  - `mem_ready`=1 → MEM_WB.
  - Otherwise stay, incrementing the wait counter.
  - Counter = `MEM_WAIT_MAX` → set `timeout`, → FETCH with no writeback.
- MEM_WB: `mem_reg`=1.
  - Rd ≠ 15: `reg_write`=1.
  - Rd = 15: load PC (`pc_write`=1, `pc_src`=1).
  - Next state is FETCH.
- MEM_WR: `reg_src`[1]=1, `mem_req`=1.
  - `mem_write`=1 in the same cycle that `mem_ready`=1, then → FETCH.
  - Same timeout rule as MEM_RD.
- BRANCH: `reg_src`[0]=1, `imm_src`=10, `alu_src`=1, `alu_control`=ADD, `pc_write`=1, `pc_src`=1. Next state is FETCH.
- Outputs are decoded from state plus the registered instruction. Any output not listed for a state is 0.

## Timing
- Reset (`rst` low, any time, including mid-wait): state → FETCH, `flags`=0000, wait counter=0, `timeout`=0.
  - While `rst` is low, all enables are forced 0.
  - The first FETCH is the first rising edge after release.
- Cycles per instruction:
  - DP with write: 4.
  - CMP / unsupported cmd: 3.
  - Branch: 3.
  - Failed condition or op 11: 2.
  - STR: 4 + wait.
  - LDR: 5 + wait.
- Wait = number of cycles `mem_ready` is low in MEM_RD/MEM_WR. `mem_ready` high on the first cycle means zero wait.
- Timeout fires after exactly `MEM_WAIT_MAX` stalled cycles. The wait counter clears on every state exit.
- Condition evaluation in DECODE uses the flags registered before it. Flags written in EXEC_DP are visible to the next instruction's DECODE.
- `mem_ready` outside MEM_RD/MEM_WR is ignored.

## Test plan
- Reset mid-LDR wait: drop `rst` during MEM_RD → all enables 0 immediately; after release, `ir_write`=1 on the first cycle; `flags`=0000.
- ADDS producing zero, e.g. E2900000 (ADDS R0,R0,#0), with `alu_flags`=0100 → 4 cycles, `reg_write` pulses in ALU_WB, `flags`=0100. A following BEQ takes BRANCH and pulses `pc_src`.
- CMP followed by a failed cond: `flags`=0000, instruction 0A000002 (BEQ) → DECODE → FETCH, 2 cycles, no `pc_write` beyond FETCH.
- LDR with 3 wait cycles → MEM_RD held 4 cycles, then `mem_reg`=1 and `reg_write`=1 for one cycle; total 8 cycles.
- STR timeout: `MEM_WAIT_MAX`=15, `mem_ready` never high → after 15 stalled cycles `timeout`=1, `mem_write` never asserted, next state FETCH.
- Unsupported cmd (e.g. EOR, cmd 0001) and op 11 → no `reg_write`/`mem_write`; 3 and 2 cycles respectively.
